config_frame_loader: RTL and testbench
======================================

CONFIG_FRAME_LOADER -- requirements
Module: config_frame_loader

Interface
REQ-001 SHALL have parameter ROWS, default 4, meaning 32-bit words per frame (FrameData width = 32*ROWS).
REQ-002 SHALL have parameter FRAMES, default 20, meaning frames per column (FrameStrobe width).
REQ-003 SHALL have parameter COLS, default 8, meaning fabric columns (ColSelect width).
REQ-004 SHALL have parameter SYNC_WORD, default 32'hFAB0_FAB1, meaning bitstream sync pattern.
REQ-005 SHALL have port CLK  input  1  sole clock, rising edge.
REQ-006 SHALL have port RST  input  1  reset, asynchronous and active-high.
REQ-007 SHALL have port in_data  input  32  bitstream word.
REQ-008 SHALL have port in_valid  input  1  in_data valid.
REQ-009 SHALL have port in_ready  output  1  loader accepts word this cycle.
REQ-010 SHALL have port FrameData  output  32*ROWS  frame bits to configuration latch D inputs; word k occupies bits [32k+31:32k].
REQ-011 SHALL have port FrameStrobe  output  FRAMES  one-hot latch enable (latch E) per frame.
REQ-012 SHALL have port ColSelect  output  COLS  one-hot column qualifier, asserted coincident with FrameStrobe.
REQ-013 SHALL have port done  output  1  end-of-bitstream seen.
REQ-014 SHALL have port error  output  1  sticky protocol error.

Function
REQ-015 SHALL transfer a word only on a rising CLK edge with in_valid=1 and in_ready=1.
REQ-016 SHALL implement states IDLE, HEADER, DATA, SETUP, STROBE, HOLD.
REQ-017 IDLE: in_ready=1; an accepted word equal to SYNC_WORD moves to HEADER and clears done and error; any other accepted word is discarded, state unchanged.
REQ-018 HEADER: in_ready=1; accepted word 32'hFFFF_FFFF sets done, moves to IDLE.
REQ-019 HEADER: any other accepted word decodes frame index = bits[4:0], column = bits[15:8]; if frame index < FRAMES and column < COLS, latch both, clear word counter, move to DATA; otherwise set error, move to IDLE.
REQ-020 DATA: in_ready=1; accepted word k (counter 0..ROWS-1) is written into shadow register slot k; SYNC_WORD here is ordinary data.
REQ-021 DATA: on acceptance of word ROWS-1, move to SETUP.
REQ-022 SETUP: in_ready=0; FrameData loads from the shadow register at the end of this cycle; move to STROBE.
REQ-023 STROBE: in_ready=0; FrameStrobe[frame] and ColSelect[column] both high for exactly this one cycle; all other bits low; move to HOLD.
REQ-024 HOLD: in_ready=0; strobes low; move to HEADER (next frame header or end word).
REQ-025 FrameData SHALL change only at the SETUP-to-STROBE edge, so it is stable for at least one cycle before, during, and one cycle after each strobe.
REQ-026 FrameStrobe and ColSelect SHALL be registered outputs, glitch-free, never more than one bit high each.
REQ-027 SHALL produce a strobe exactly 3 cycles after acceptance of the last data word (SETUP, then STROBE).
REQ-028 in_valid low in any accepting state SHALL stall with state and counter unchanged; no timeout.
REQ-029 error SHALL remain set until RST or the next accepted SYNC_WORD in IDLE; done likewise.

Reset
REQ-030 RST high SHALL immediately force state IDLE, counter 0, shadow and FrameData all zero, FrameStrobe=0, ColSelect=0, done=0, error=0, in_ready=0 while RST high.
REQ-031 RST asserted mid-frame SHALL discard the partial frame with no strobe issued; the first cycle after release SHALL be IDLE with in_ready=1.

Verification
REQ-032 Bench: SYNC_WORD, header 32'h0000_0305, words 11111111,22222222,33333333,44444444 (ROWS=4) -> FrameData=128'h44444444_33333333_22222222_11111111, one-cycle FrameStrobe=20'h00020 with ColSelect=8'h08, three cycles after the last word.
REQ-033 Bench: two frames back-to-back after one sync, second header 32'h0000_0013 -> second strobe FrameStrobe bit 19, ColSelect=8'h01, first frame's FrameData held until the second SETUP edge.
REQ-034 Bench: sync then header 32'h0000_0014 (frame 20) -> error=1, no strobe, state IDLE; next SYNC_WORD clears error.
REQ-035 Bench: garbage 32'hDEAD_BEEF before sync, then sync, end word 32'hFFFF_FFFF -> word ignored, done=1, no strobe.
REQ-036 Bench: in_valid toggling every other cycle during DATA, plus RST pulse after word 2 of a frame -> stall correctness; after reset all outputs zero and no strobe ever issued for that frame.

Source files
------------

// File: rtl/config_frame_loader.sv
// ---------------------------------------------------------------------------
// config_frame_loader
//
// Streams a configuration bitstream into fabric configuration latches.
// The loader hunts for SYNC_WORD, then reads a sequence of frame headers.
// Each header names a frame and a column and is followed by ROWS data words.
// The data words are collected in a shadow register and copied to FrameData.
// One cycle later a single-cycle one-hot FrameStrobe/ColSelect pulse fires.
// A header of all ones ends the bitstream. An out-of-range header flags a
// sticky error and sends the loader back to hunting for sync.
//
// Ports
//   CLK          rising-edge clock
//   RST          asynchronous active-high reset
//   in_data      bitstream word
//   in_valid     in_data valid
//   in_ready     loader accepts a word this cycle
//   FrameData    frame bits to the latch D inputs; word k sits at [32k+31:32k]
//   FrameStrobe  one-hot latch enable, one bit per frame
//   ColSelect    one-hot column qualifier, coincident with FrameStrobe
//   done         end-of-bitstream word seen (cleared by the next sync)
//   error        sticky protocol error (cleared by the next sync)
//   state_dbg    current FSM state:
//                IDLE=0, HEADER=1, DATA=2, SETUP=3, STROBE=4, HOLD=5
//
// Handshake: a word transfers on a rising CLK edge where in_valid and
// in_ready are both 1. in_ready never depends on in_valid. A source may hold
// in_valid low for any number of cycles, and the loader then waits with its
// state untouched.
//
// Strobe timing: FrameData is loaded on the SETUP->STROBE edge. The strobe
// registers are loaded on the STROBE->HOLD edge. So the latch-enable pulse
// starts one full cycle after FrameData settled, and FrameData is held for
// at least one cycle after the pulse. The pulse appears in the third cycle
// after the cycle in which the last data word was accepted.
// ---------------------------------------------------------------------------
module config_frame_loader #(
    parameter int          ROWS      = 4,
    parameter int          FRAMES    = 20,
    parameter int          COLS      = 8,
    parameter logic [31:0] SYNC_WORD = 32'hFAB0_FAB1
) (
    input  logic                 CLK,
    input  logic                 RST,
    input  logic [31:0]          in_data,
    input  logic                 in_valid,
    output logic                 in_ready,
    output logic [32*ROWS-1:0]   FrameData,
    output logic [FRAMES-1:0]    FrameStrobe,
    output logic [COLS-1:0]      ColSelect,
    output logic                 done,
    output logic                 error,
    output logic [2:0]           state_dbg
);

    localparam logic [31:0] END_WORD   = 32'hFFFF_FFFF;
    localparam int          CW         = (ROWS > 1) ? $clog2(ROWS) : 1;
    localparam logic [CW-1:0] LAST_WORD = CW'(ROWS - 1);
    localparam logic [31:0] FRAMES_LIM = 32'(FRAMES);
    localparam logic [31:0] COLS_LIM   = 32'(COLS);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_HEADER = 3'd1,
        S_DATA   = 3'd2,
        S_SETUP  = 3'd3,
        S_STROBE = 3'd4,
        S_HOLD   = 3'd5
    } state_t;

    state_t          state;
    state_t          state_nx;
    logic [CW-1:0]   word_cnt;
    logic [4:0]      frame_sel;
    logic [7:0]      col_sel;
    logic [31:0]     shadow [ROWS];
    logic            accept;
    logic            is_sync;
    logic            hdr_end;
    logic            hdr_ok;

    assign accept  = in_valid & in_ready;
    assign is_sync = (in_data == SYNC_WORD);
    assign hdr_end = (in_data == END_WORD);
    // The header is usable only if both fields address an existing latch.
    assign hdr_ok  = ({27'd0, in_data[4:0]} < FRAMES_LIM) &&
                     ({24'd0, in_data[15:8]} < COLS_LIM);

    assign state_dbg = state;

    // State register
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state <= S_IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // Next-state logic
    always_comb begin
        state_nx = state;
        case (state)
            S_IDLE:   if (accept && is_sync) state_nx = S_HEADER;
            S_HEADER: if (accept) state_nx = (hdr_end || !hdr_ok) ? S_IDLE : S_DATA;
            S_DATA:   if (accept && word_cnt == LAST_WORD) state_nx = S_SETUP;
            S_SETUP:  state_nx = S_STROBE;
            S_STROBE: state_nx = S_HOLD;
            S_HOLD:   state_nx = S_HEADER;
            default:  state_nx = S_IDLE;
        endcase
    end

    // Output logic: in_ready is held low throughout reset.
    always_comb begin
        in_ready = 1'b0;
        if (!RST) begin
            case (state)
                S_IDLE, S_HEADER, S_DATA: in_ready = 1'b1;
                default:                  in_ready = 1'b0;
            endcase
        end
    end

    // Datapath: header fields, shadow capture, frame output, strobes, flags
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            word_cnt    <= '0;
            frame_sel   <= '0;
            col_sel     <= '0;
            FrameData   <= '0;
            FrameStrobe <= '0;
            ColSelect   <= '0;
            done        <= 1'b0;
            error       <= 1'b0;
            for (int k = 0; k < ROWS; k++) shadow[k] <= '0;
        end else begin
            // The strobes are single-cycle pulses unless reloaded below.
            FrameStrobe <= '0;
            ColSelect   <= '0;
            case (state)
                S_IDLE: begin
                    if (accept && is_sync) begin
                        done  <= 1'b0;
                        error <= 1'b0;
                    end
                end
                S_HEADER: begin
                    if (accept) begin
                        if (hdr_end) begin
                            done <= 1'b1;
                        end else if (hdr_ok) begin
                            frame_sel <= in_data[4:0];
                            col_sel   <= in_data[15:8];
                            word_cnt  <= '0;
                        end else begin
                            error <= 1'b1;
                        end
                    end
                end
                S_DATA: begin
                    if (accept) begin
                        shadow[word_cnt] <= in_data;
                        word_cnt         <= word_cnt + 1'b1;
                    end
                end
                S_SETUP: begin
                    for (int k = 0; k < ROWS; k++) FrameData[32*k +: 32] <= shadow[k];
                end
                S_STROBE: begin
                    FrameStrobe <= FRAMES'(1) << frame_sel;
                    ColSelect   <= COLS'(1) << col_sel;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_config_frame_loader.sv
// ---------------------------------------------------------------------------
// tb_config_frame_loader
//
// Bench for config_frame_loader. It uses default parameters:
// ROWS=4, FRAMES=20, COLS=8.
//
// Contents:
//   - a header-decode vector table applied in a loop
//   - hand-written sequences for the multi-cycle corner cases
//   - randomized bitstreams scored against a bitstream parser model
//
// A negedge monitor captures every strobe pulse together with FrameData.
// For each pulse it records whether FrameData was stable in the cycle before
// the pulse and in the cycle after it. The main process compares those
// records against the expected queue.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_config_frame_loader;

    localparam int          ROWS   = 4;
    localparam int          FRAMES = 20;
    localparam int          COLS   = 8;
    localparam int          FDW    = 32 * ROWS;
    localparam int          EXP_W  = FDW + FRAMES + COLS;
    localparam logic [31:0] SYNC   = 32'hFAB0_FAB1;
    localparam logic [31:0] ENDW   = 32'hFFFF_FFFF;

    // ---------------- clock / reset / DUT ----------------
    logic              CLK = 1'b0;
    logic              RST = 1'b0;
    logic [31:0]       in_data = '0;
    logic              in_valid = 1'b0;
    logic              in_ready;
    logic [FDW-1:0]    FrameData;
    logic [FRAMES-1:0] FrameStrobe;
    logic [COLS-1:0]   ColSelect;
    logic              done;
    logic              error;
    logic [2:0]        state_dbg;

    always #5 CLK = ~CLK;

    int cyc = 0;
    always @(posedge CLK) cyc <= cyc + 1;

    config_frame_loader #(
        .ROWS(ROWS), .FRAMES(FRAMES), .COLS(COLS), .SYNC_WORD(SYNC)
    ) dut (
        .CLK(CLK), .RST(RST), .in_data(in_data), .in_valid(in_valid),
        .in_ready(in_ready), .FrameData(FrameData), .FrameStrobe(FrameStrobe),
        .ColSelect(ColSelect), .done(done), .error(error), .state_dbg(state_dbg)
    );

    initial begin
        #500us;
        $display("FAIL watchdog: simulation still running at %0t, required to finish earlier", $time);
        $fatal(1, "watchdog expired");
    end

    // ---------------- strobe monitor ----------------
    typedef struct {
        logic [FDW-1:0]    fd;
        logic [FRAMES-1:0] fs;
        logic [COLS-1:0]   cs;
        int                cyc;
        bit                before_ok;
        bit                after_ok;
    } obs_t;

    obs_t           obs_q[$];
    obs_t           pend;
    bit             pend_v  = 1'b0;
    logic [FDW-1:0] prev_fd = '0;

    always @(negedge CLK) begin
        if (pend_v) begin
            pend.after_ok = (FrameData == pend.fd) && (FrameStrobe == '0) && (ColSelect == '0);
            obs_q.push_back(pend);
            pend_v = 1'b0;
        end
        if (FrameStrobe != '0 || ColSelect != '0) begin
            pend.fd        = FrameData;
            pend.fs        = FrameStrobe;
            pend.cs        = ColSelect;
            pend.cyc       = cyc;
            pend.before_ok = (prev_fd == FrameData);
            pend.after_ok  = 1'b0;
            pend_v         = 1'b1;
        end
        prev_fd = FrameData;
    end

    // ---------------- scoreboard ----------------
    int               checks = 0;
    int               errors = 0;
    int               obs_rd = 0;
    logic [EXP_W-1:0] exp_q[$];

    task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, required %0h", name, act, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge CLK);
    endtask

    // Compare every captured strobe against the expected queue.
    // Afterwards, no expected strobe may be left outstanding.
    task automatic drain(input string tag);
        obs_t             o;
        logic [EXP_W-1:0] e;
        while (obs_rd < obs_q.size()) begin
            o = obs_q[obs_rd];
            obs_rd++;
            chk({tag, "_onehot"}, {30'd0, $onehot(o.fs), $onehot(o.cs)}, 32'd3);
            chk({tag, "_fd_stable"}, {30'd0, o.before_ok, o.after_ok}, 32'd3);
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL %s_extra_strobe: got fs=%0h cs=%0h, required no strobe", tag, o.fs, o.cs);
            end else begin
                e = exp_q.pop_front();
                chk({tag, "_strobe"}, {o.fd, o.fs, o.cs}, e);
            end
        end
        chk({tag, "_missing"}, exp_q.size(), 0);
        exp_q.delete();
    endtask

    // ---------------- driver tasks ----------------
    // Hold in_valid low for a random gap of gmin..gmax cycles, then offer w.
    // Wait a bounded time for in_ready. acc returns the cycle count right
    // after the accepting edge, or -1 if the bound expired.
    task automatic send_word(input logic [31:0] w, input int gmin, input int gmax, output int acc);
        int waited;
        @(negedge CLK);
        in_valid = 1'b0;
        repeat ($urandom_range(gmax, gmin)) @(negedge CLK);
        in_data  = w;
        in_valid = 1'b1;
        waited   = 0;
        while (!in_ready && waited < 40) begin
            @(negedge CLK);
            waited++;
        end
        if (!in_ready) begin
            checks++;
            errors++;
            $display("FAIL accept_timeout: word %h not accepted after %0d cycles, required acceptance", w, waited);
            in_valid = 1'b0;
            acc = -1;
        end else begin
            @(posedge CLK);
            #1;
            in_valid = 1'b0;
            acc = cyc;
        end
    endtask

    task automatic do_reset(input string tag);
        @(negedge CLK);
        RST = 1'b1;
        in_valid = 1'b0;
        #1;
        chk({tag, "_rst_outputs"}, {in_ready, FrameData, FrameStrobe, ColSelect, done, error}, '0);
        repeat (2) @(negedge CLK);
        RST = 1'b0;
        @(negedge CLK);
        chk({tag, "_post_rst_idle"}, {in_ready, state_dbg}, {1'b1, 3'd0});
    endtask

    // ---------------- reference model ----------------
    // Parse a whole word stream as the source intends it. Pending frames go
    // to exp_q. The flag values at the end of the stream are returned.
    task automatic model_stream(input logic [31:0] w[$], output logic m_done, output logic m_err);
        int             i;
        int             n;
        logic [31:0]    h;
        logic [FDW-1:0] fd;
        logic [FRAMES-1:0] fs;
        logic [COLS-1:0]   cs;
        i = 0;
        n = w.size();
        m_done = 1'b0;
        m_err  = 1'b0;
        while (i < n) begin
            while (i < n && w[i] != SYNC) i++;
            if (i >= n) break;
            i++;
            m_done = 1'b0;
            m_err  = 1'b0;
            while (i < n) begin
                h = w[i];
                i++;
                if (h == ENDW) begin
                    m_done = 1'b1;
                    break;
                end
                if (int'(h[4:0]) >= FRAMES || int'(h[15:8]) >= COLS) begin
                    m_err = 1'b1;
                    break;
                end
                if (i + ROWS > n) begin
                    i = n;
                    break;
                end
                for (int k = 0; k < ROWS; k++) fd[32*k +: 32] = w[i+k];
                i += ROWS;
                fs = '0;
                fs[h[4:0]] = 1'b1;
                cs = '0;
                cs[h[15:8]] = 1'b1;
                exp_q.push_back({fd, fs, cs});
            end
        end
    endtask

    // ---------------- header-decode table ----------------
    typedef struct {
        logic [31:0]       hdr;
        logic [FRAMES-1:0] fs;
        logic [COLS-1:0]   cs;
        logic              err;
    } vec_t;

    vec_t vecs[8];

    // ---------------- test sequence ----------------
    initial begin
        int             acc;
        logic [FDW-1:0] fd1;
        logic [FDW-1:0] fd2;
        logic [31:0]    r;
        logic [31:0]    ws[$];
        logic           m_done;
        logic           m_err;
        int             nf;

        vecs[0] = '{32'h0000_0305, 20'h00020, 8'h08, 1'b0};
        vecs[1] = '{32'h0000_0013, 20'h80000, 8'h01, 1'b0};
        vecs[2] = '{32'h0000_0014, 20'h00000, 8'h00, 1'b1};
        vecs[3] = '{32'h0000_0800, 20'h00000, 8'h00, 1'b1};
        vecs[4] = '{32'h0000_0700, 20'h00001, 8'h80, 1'b0};
        vecs[5] = '{32'hABCD_07F2, 20'h40000, 8'h80, 1'b0};
        vecs[6] = '{32'h0000_001F, 20'h00000, 8'h00, 1'b1};
        vecs[7] = '{32'h0000_FF00, 20'h00000, 8'h00, 1'b1};

        do_reset("init");

        // Reference frame: exact data, strobe position and latency.
        fd1 = 128'h44444444_33333333_22222222_11111111;
        send_word(SYNC, 0, 0, acc);
        send_word(32'h0000_0305, 0, 0, acc);
        for (int k = 0; k < ROWS; k++) send_word(fd1[32*k +: 32], 0, 0, acc);
        exp_q.push_back({fd1, 20'h00020, 8'h08});
        tick(5);
        // Acceptance cycle, SETUP, STROBE, then the pulse: the pulse is seen
        // two rising edges after the edge that accepted the last word.
        chk("r032_latency", (obs_q.size() > obs_rd) ? obs_q[obs_rd].cyc - acc : -1, 2);
        drain("r032");

        // Back-to-back frame: the first FrameData is held until the second
        // SETUP edge.
        fd2 = 128'h0BADF00D_CAFEBABE_12345678_9ABCDEF0;
        send_word(32'h0000_0013, 0, 0, acc);
        for (int k = 0; k < ROWS - 1; k++) send_word(fd2[32*k +: 32], 0, 0, acc);
        chk("r033_hold_in_data", FrameData, fd1);
        send_word(fd2[32*(ROWS-1) +: 32], 0, 0, acc);
        @(negedge CLK);
        chk("r033_hold_in_setup", FrameData, fd1);
        @(negedge CLK);
        chk("r033_load_after_setup", FrameData, fd2);
        exp_q.push_back({fd2, 20'h80000, 8'h01});
        tick(4);
        chk("r033_latency", (obs_q.size() > obs_rd) ? obs_q[obs_rd].cyc - acc : -1, 2);
        drain("r033");
        send_word(ENDW, 0, 0, acc);
        tick(1);
        chk("r033_done", {done, error}, 2'b10);

        // Out-of-range frame: error, back to hunting for sync, and later
        // headers are ignored until sync.
        send_word(SYNC, 0, 0, acc);
        tick(1);
        chk("r034_sync_clears_done", {done, error}, 2'b00);
        send_word(32'h0000_0014, 0, 0, acc);
        tick(2);
        chk("r034_error", {error, done, in_ready}, 3'b101);
        send_word(32'h0000_0305, 0, 0, acc);
        for (int k = 0; k < ROWS; k++) send_word($urandom(), 0, 0, acc);
        tick(5);
        chk("r034_error_sticky", error, 1'b1);
        drain("r034_no_strobe");
        send_word(SYNC, 0, 0, acc);
        tick(1);
        chk("r034_sync_clears_error", error, 1'b0);
        send_word(ENDW, 0, 0, acc);

        // Garbage before sync, then an empty bitstream.
        do_reset("r035");
        send_word(32'hDEAD_BEEF, 0, 0, acc);
        tick(1);
        chk("r035_garbage_ignored", {done, error, in_ready}, 3'b001);
        send_word(SYNC, 0, 0, acc);
        send_word(ENDW, 0, 0, acc);
        tick(4);
        chk("r035_done", {done, error}, 2'b10);
        drain("r035_no_strobe");

        // in_valid toggling during DATA, then reset in the middle of a frame.
        do_reset("r036a");
        fd1 = {$urandom(), $urandom(), $urandom(), $urandom()};
        send_word(SYNC, 1, 1, acc);
        send_word(32'h0000_0102, 1, 1, acc);
        for (int k = 0; k < ROWS; k++) send_word(fd1[32*k +: 32], 1, 1, acc);
        exp_q.push_back({fd1, 20'h00004, 8'h02});
        tick(5);
        drain("r036_toggle");
        send_word(32'h0000_0013, 1, 1, acc);
        send_word($urandom(), 1, 1, acc);
        send_word($urandom(), 1, 1, acc);
        do_reset("r036b");
        tick(10);
        chk("r036_flags_after_rst", {done, error, FrameData}, '0);
        drain("r036_no_strobe");

        // Header-decode table.
        for (int v = 0; v < 8; v++) begin
            send_word(SYNC, 0, 1, acc);
            send_word(vecs[v].hdr, 0, 1, acc);
            if (!vecs[v].err) begin
                for (int k = 0; k < ROWS; k++) begin
                    r = $urandom();
                    fd1[32*k +: 32] = r;
                    send_word(r, 0, 1, acc);
                end
                exp_q.push_back({fd1, vecs[v].fs, vecs[v].cs});
                send_word(ENDW, 0, 0, acc);
                tick(3);
                chk($sformatf("vec%0d_flags", v), {done, error}, 2'b10);
            end else begin
                tick(2);
                chk($sformatf("vec%0d_flags", v), {done, error, in_ready}, 3'b011);
            end
            drain($sformatf("vec%0d", v));
        end

        // Randomized bitstreams scored by the parser model.
        for (int s = 0; s < 10; s++) begin
            do_reset($sformatf("rnd%0d", s));
            ws.delete();
            if ($urandom_range(1, 0) == 1) begin
                r = $urandom();
                if (r == SYNC) r = 32'h0;
                ws.push_back(r);
            end
            ws.push_back(SYNC);
            nf = $urandom_range(3, 1);
            for (int f = 0; f < nf; f++) begin
                r = $urandom();
                if ($urandom_range(5, 0) == 0) begin
                    if ($urandom_range(1, 0) == 1)
                        r[4:0] = 5'($urandom_range(31, FRAMES));
                    else
                        r[15:8] = 8'($urandom_range(255, COLS));
                end else begin
                    r[4:0]  = 5'($urandom_range(FRAMES - 1, 0));
                    r[15:8] = 8'($urandom_range(COLS - 1, 0));
                end
                ws.push_back(r);
                for (int k = 0; k < ROWS; k++) ws.push_back($urandom());
            end
            if ($urandom_range(1, 0) == 1) ws.push_back(ENDW);
            model_stream(ws, m_done, m_err);
            foreach (ws[j]) send_word(ws[j], 0, 2, acc);
            tick(8);
            chk($sformatf("rnd%0d_flags", s), {done, error}, {m_done, m_err});
            drain($sformatf("rnd%0d", s));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
